watch_counter_core: RTL and testbench
=====================================

WATCH_COUNTER_CORE -- requirements
Module: watch_counter_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100: fractional-second tick rate; CLK_HZ SHALL be an exact multiple of TICK_HZ, with DIV = CLK_HZ/TICK_HZ >= 2.
REQ-003 SHALL have parameter HOUR_MAX, default 24: hour modulus, range 2..99.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port i_run_toggle, input, 1 bit: single-cycle pulse that starts or pauses counting.
REQ-007 SHALL have port i_clear, input, 1 bit: single-cycle pulse that zeroes all counts.
REQ-008 SHALL have port i_lap, input, 1 bit: single-cycle pulse that captures a lap time.
REQ-009 SHALL have port o_running, output, 1 bit: high in state RUN.
REQ-010 SHALL have port o_tick, output, 1 bit: one-cycle pulse per fractional increment.
REQ-011 SHALL have port o_frac, output, $clog2(TICK_HZ) bits: fraction of a second, 0..TICK_HZ-1.
REQ-012 SHALL have ports o_sec and o_min, output, 6 bits each: 0..59.
REQ-013 SHALL have port o_hour, output, 7 bits: 0..HOUR_MAX-1.
REQ-014 SHALL have port o_wrap, output, 1 bit: one-cycle pulse when the full count rolls over to zero.
REQ-015 SHALL have ports o_lap_frac, o_lap_sec, o_lap_min and o_lap_hour, outputs, same widths as the live counts: captured lap time.
REQ-016 SHALL have port o_lap_valid, output, 1 bit: a lap is held.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN and PAUSE.
REQ-018 SHALL make these transitions on i_run_toggle: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-019 SHALL, on i_clear in any state, go to IDLE; zero the divider, all counts and the lap registers; and clear o_lap_valid. i_clear SHALL dominate a simultaneous i_run_toggle or i_lap.
REQ-020 SHALL run the divider (0..DIV-1) only in RUN, hold it in PAUSE, and hold it at 0 in IDLE.
REQ-021 SHALL, at the edge where the divider equals DIV-1 in RUN, reload the divider to 0 and increment o_frac; o_tick SHALL be high for exactly the following cycle.
REQ-022 SHALL cascade carries as follows: o_frac TICK_HZ-1->0 increments o_sec; o_sec 59->0 increments o_min; o_min 59->0 increments o_hour; o_hour HOUR_MAX-1->0 sets o_wrap high for one cycle, aligned with o_tick.
REQ-023 SHALL, when i_run_toggle RUN->PAUSE coincides with a terminal divider count, apply that increment before pausing.
REQ-024 SHALL, on i_lap in RUN, capture the count values present before that edge's increment and set o_lap_valid; i_lap SHALL be ignored in IDLE and PAUSE.
REQ-025 SHALL let a later lap overwrite the earlier one.
REQ-026 SHALL drive all outputs directly from registers.

Reset
REQ-027 SHALL, on reset assertion, immediately place the FSM in IDLE and drive every output and internal register to 0.
REQ-028 SHALL resume operation on the first rising clk edge after reset deassertion.

Configuration
REQ-029 SHALL support macro WATCH_LAP_CAPTURE_EN: when defined, lap capture is implemented per REQ-024/025.
REQ-030 SHALL, when WATCH_LAP_CAPTURE_EN is undefined, tie o_lap_* and o_lap_valid to 0, ignore i_lap, and leave no lap registers in the design.

Structure
REQ-031 SHALL place the FSM state enum, SEC_MAX=60 and MIN_MAX=60 in shared package watch_pkg.
REQ-032 SHALL implement the divider as sub-module watch_tick_gen (parameter DIV; inputs enable and hold_zero; output terminal-count strobe).

Verification (CLK_HZ=1000, TICK_HZ=100, DIV=10, HOUR_MAX=2)
REQ-033 SHALL cover: reset then i_run_toggle -> first o_tick 10 cycles after RUN entry, then every 10 cycles; o_frac counts 1,2,...
REQ-034 SHALL cover: run 100 ticks -> o_frac=0 and o_sec=1 on tick 100; at 2*60*60*100 ticks -> o_wrap pulse with all counts 0.
REQ-035 SHALL cover: pause at divider 4 for 50 cycles, then resume -> next o_tick 6 cycles after resume; counts unchanged while paused.
REQ-036 SHALL cover: i_lap at frac=37, sec=2 -> o_lap_frac=37, o_lap_sec=2, o_lap_valid=1; live count continues; i_lap in PAUSE -> lap unchanged.
REQ-037 SHALL cover: i_clear together with i_run_toggle in RUN -> IDLE, all counts 0, o_running=0, o_lap_valid=0.
REQ-038 SHALL cover: reset asserted mid-RUN without a clk edge -> all outputs 0 immediately; build without WATCH_LAP_CAPTURE_EN -> o_lap_* stay 0 under i_lap.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the stopwatch core.
// Holds the FSM state enum and the sec/min moduli.
package watch_pkg;

  localparam int SEC_MAX = 60;
  localparam int MIN_MAX = 60;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/watch_tick_gen.sv
// Clock divider producing a terminal-count strobe every DIV enabled cycles.
// Ports: clk, reset, enable (count), hold_zero (force 0), tc (terminal strobe).
module watch_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic hold_zero,
  output logic tc
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tc = enable && !hold_zero && (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (hold_zero) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/watch_counter_core.sv
// Stopwatch core: IDLE/RUN/PAUSE FSM, frac/sec/min/hour cascade, lap capture.
// Ports: clk, reset, i_run_toggle/i_clear/i_lap pulses; o_* registered counts,
// tick/wrap strobes, lap snapshot. Lap logic exists only with WATCH_LAP_CAPTURE_EN.
module watch_counter_core
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MAX = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_run_toggle,
  input  logic                       i_clear,
  input  logic                       i_lap,
  output logic                       o_running,
  output logic                       o_tick,
  output logic [$clog2(TICK_HZ)-1:0] o_frac,
  output logic [5:0]                 o_sec,
  output logic [5:0]                 o_min,
  output logic [6:0]                 o_hour,
  output logic                       o_wrap,
  output logic [$clog2(TICK_HZ)-1:0] o_lap_frac,
  output logic [5:0]                 o_lap_sec,
  output logic [5:0]                 o_lap_min,
  output logic [6:0]                 o_lap_hour,
  output logic                       o_lap_valid
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int FW  = $clog2(TICK_HZ);

  state_e state_q;
  state_e state_d;
  logic   run;
  logic   tc;
  logic   inc;
  logic   frac_top;
  logic   sec_top;
  logic   min_top;
  logic   hour_top;

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else if (i_run_toggle) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign run = (state_q == ST_RUN);

  watch_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (run),
    .hold_zero((state_q == ST_IDLE) || i_clear),
    .tc       (tc)
  );

  // An increment due on the same edge as a pause still lands.
  assign inc      = run && tc;
  assign frac_top = (o_frac == FW'(TICK_HZ - 1));
  assign sec_top  = (o_sec == 6'(SEC_MAX - 1));
  assign min_top  = (o_min == 6'(MIN_MAX - 1));
  assign hour_top = (o_hour == 7'(HOUR_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      o_running <= 1'b0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
      o_frac    <= '0;
      o_sec     <= '0;
      o_min     <= '0;
      o_hour    <= '0;
    end else begin
      state_q   <= state_d;
      o_running <= (state_d == ST_RUN);
      if (i_clear) begin
        o_tick <= 1'b0;
        o_wrap <= 1'b0;
        o_frac <= '0;
        o_sec  <= '0;
        o_min  <= '0;
        o_hour <= '0;
      end else begin
        o_tick <= inc;
        o_wrap <= inc && frac_top && sec_top
                  && min_top && hour_top;
        if (inc) begin
          o_frac <= frac_top ? '0 : o_frac + 1'b1;
          if (frac_top) begin
            o_sec <= sec_top ? '0 : o_sec + 1'b1;
            if (sec_top) begin
              o_min <= min_top ? '0 : o_min + 1'b1;
              if (min_top) begin
                o_hour <= hour_top ? '0 : o_hour + 1'b1;
              end
            end
          end
        end
      end
    end
  end

`ifdef WATCH_LAP_CAPTURE_EN
  // Snapshot takes the pre-increment count of this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_lap_frac  <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_hour  <= '0;
      o_lap_valid <= 1'b0;
    end else if (i_clear) begin
      o_lap_frac  <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_hour  <= '0;
      o_lap_valid <= 1'b0;
    end else if (i_lap && run) begin
      o_lap_frac  <= o_frac;
      o_lap_sec   <= o_sec;
      o_lap_min   <= o_min;
      o_lap_hour  <= o_hour;
      o_lap_valid <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap  = i_lap;
  assign o_lap_frac  = '0;
  assign o_lap_sec   = '0;
  assign o_lap_min   = '0;
  assign o_lap_hour  = '0;
  assign o_lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_watch_counter_core.sv
// Self-checking bench for watch_counter_core against a tick-count model.
// Second instance with a tiny divider exercises the full-day rollover.
module tb_watch_counter_core;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int HM      = 2;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int W_CLK   = 4;
  localparam int W_TICK  = 2;
  localparam int W_DIV   = W_CLK / W_TICK;
  localparam longint TOT1 = longint'(HM) * 3600 * TICK_HZ;
  localparam longint TOT2 = longint'(HM) * 3600 * W_TICK;
`ifdef WATCH_LAP_CAPTURE_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct {
    int     mode;
    int     div;
    longint ticks;
    bit     tick;
    bit     wrap;
    longint lap_ticks;
    bit     lap_valid;
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tg = 1'b0, clr = 1'b0, lp = 1'b0;
  logic w_tg = 1'b0, w_clr = 1'b0, w_lp = 1'b0;

  logic       running, tick, wrap, lap_valid;
  logic [6:0] frac, lap_frac;
  logic [5:0] sec, min, lap_sec, lap_min;
  logic [6:0] hour, lap_hour;

  logic       w_running, w_tick, w_wrap, w_lap_valid;
  logic [0:0] w_frac, w_lap_frac;
  logic [5:0] w_sec, w_min, w_lap_sec, w_lap_min;
  logic [6:0] w_hour, w_lap_hour;

  int   n_assert = 0;
  int   n_fail   = 0;
  mdl_t m1, m2;

  always #5 clk = ~clk;

  watch_counter_core #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HM)
  ) u_dut (
    .clk(clk), .reset(reset),
    .i_run_toggle(tg), .i_clear(clr), .i_lap(lp),
    .o_running(running), .o_tick(tick),
    .o_frac(frac), .o_sec(sec), .o_min(min), .o_hour(hour),
    .o_wrap(wrap),
    .o_lap_frac(lap_frac), .o_lap_sec(lap_sec),
    .o_lap_min(lap_min), .o_lap_hour(lap_hour),
    .o_lap_valid(lap_valid)
  );

  watch_counter_core #(
    .CLK_HZ(W_CLK), .TICK_HZ(W_TICK), .HOUR_MAX(HM)
  ) u_wrap (
    .clk(clk), .reset(reset),
    .i_run_toggle(w_tg), .i_clear(w_clr), .i_lap(w_lp),
    .o_running(w_running), .o_tick(w_tick),
    .o_frac(w_frac), .o_sec(w_sec), .o_min(w_min), .o_hour(w_hour),
    .o_wrap(w_wrap),
    .o_lap_frac(w_lap_frac), .o_lap_sec(w_lap_sec),
    .o_lap_min(w_lap_min), .o_lap_hour(w_lap_hour),
    .o_lap_valid(w_lap_valid)
  );

  // Field k of an elapsed tick count: 0 frac, 1 sec, 2 min, 3 hour.
  function automatic longint fld(longint t, int th, int k);
    case (k)
      0:       return t % th;
      1:       return (t / th) % 60;
      2:       return (t / (th * 60)) % 60;
      default: return t / (th * 3600);
    endcase
  endfunction

  // mode: 0 idle, 1 running, 2 paused; div counts enabled cycles.
  function automatic mdl_t mstep(mdl_t m, bit t, bit c, bit l,
                                 int dv, longint tot);
    mdl_t n = m;
    n.tick = 1'b0;
    n.wrap = 1'b0;
    if (c) begin
      n = '{default: 0};
      return n;
    end
    if (m.mode == 1) begin
      if (LAP_EN && l) begin
        n.lap_ticks = m.ticks;
        n.lap_valid = 1'b1;
      end
      if (m.div == dv - 1) begin
        n.div   = 0;
        n.ticks = (m.ticks + 1) % tot;
        n.tick  = 1'b1;
        n.wrap  = (n.ticks == 0);
      end else begin
        n.div = m.div + 1;
      end
    end
    if (t) n.mode = (m.mode == 1) ? 2 : 1;
    return n;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_main();
    chk("running", running, m1.mode == 1);
    chk("tick", tick, m1.tick);
    chk("wrap", wrap, m1.wrap);
    chk("frac", frac, fld(m1.ticks, TICK_HZ, 0));
    chk("sec", sec, fld(m1.ticks, TICK_HZ, 1));
    chk("min", min, fld(m1.ticks, TICK_HZ, 2));
    chk("hour", hour, fld(m1.ticks, TICK_HZ, 3));
    chk("lap_valid", lap_valid, m1.lap_valid);
    chk("lap_frac", lap_frac, fld(m1.lap_ticks, TICK_HZ, 0));
    chk("lap_sec", lap_sec, fld(m1.lap_ticks, TICK_HZ, 1));
    chk("lap_min", lap_min, fld(m1.lap_ticks, TICK_HZ, 2));
    chk("lap_hour", lap_hour, fld(m1.lap_ticks, TICK_HZ, 3));
  endtask

  task automatic check_wrap_inst();
    chk("w_running", w_running, m2.mode == 1);
    chk("w_tick", w_tick, m2.tick);
    chk("w_wrap", w_wrap, m2.wrap);
    chk("w_frac", w_frac, fld(m2.ticks, W_TICK, 0));
    chk("w_sec", w_sec, fld(m2.ticks, W_TICK, 1));
    chk("w_min", w_min, fld(m2.ticks, W_TICK, 2));
    chk("w_hour", w_hour, fld(m2.ticks, W_TICK, 3));
  endtask

  task automatic cyc();
    @(posedge clk);
    m1 = mstep(m1, tg, clr, lp, DIV, TOT1);
    m2 = mstep(m2, w_tg, w_clr, w_lp, W_DIV, TOT2);
    @(negedge clk);
    check_main();
    check_wrap_inst();
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_count"}, {frac, sec, min, hour}, 0);
    chk({tag, "_lap"}, {lap_frac, lap_sec, lap_min, lap_hour}, 0);
    chk({tag, "_lap_valid"}, lap_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [6:0] hold_frac;
    logic [5:0] hold_sec;
    bit got;
    m1 = '{default: 0};
    m2 = '{default: 0};

    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    chk("w_reset_count", {w_frac, w_sec, w_min, w_hour}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Start: first tick 10 cycles after RUN entry, then every 10.
    tg = 1'b1; cyc(); tg = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cyc(); n++; got = tick;
    end
    chk("first_tick_lat", n, 10);
    chk("first_tick_frac", frac, 1);
    n = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cyc(); n++; got = tick;
    end
    chk("second_tick_lat", n, 10);
    chk("second_tick_frac", frac, 2);

    // 100 ticks: frac rolls into sec.
    for (int i = 0; i < 2000 && m1.ticks < 100; i++) cyc();
    chk("t100_frac", frac, 0);
    chk("t100_sec", sec, 1);
    chk("t100_tick", tick, 1);

    // Lap at 2.37 s.
    for (int i = 0; i < 2000 && m1.ticks < 237; i++) cyc();
    lp = 1'b1; cyc(); lp = 1'b0;
    chk("lap_frac37", lap_frac, LAP_EN ? 37 : 0);
    chk("lap_sec2", lap_sec, LAP_EN ? 2 : 0);
    chk("lap_valid1", lap_valid, LAP_EN);
    repeat (30) cyc();

    // Pause with divider at 4, hold 50 cycles, resume.
    for (int i = 0; i < 30 && m1.div != 3; i++) cyc();
    tg = 1'b1; cyc(); tg = 1'b0;
    hold_frac = frac;
    hold_sec  = sec;
    repeat (25) cyc();
    lp = 1'b1; cyc(); lp = 1'b0;
    repeat (24) cyc();
    chk("pause_running", running, 0);
    chk("pause_frac_hold", frac, hold_frac);
    chk("pause_sec_hold", sec, hold_sec);
    chk("pause_lap_hold", lap_frac, LAP_EN ? 37 : 0);
    tg = 1'b1; cyc(); tg = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cyc(); n++; got = tick;
    end
    chk("resume_tick_lat", n, 6);

    // Random pulses against the model.
    for (int i = 0; i < 2500 && n_fail < 40; i++) begin
      tg  = ($urandom_range(39) == 0);
      lp  = ($urandom_range(29) == 0);
      clr = ($urandom_range(499) == 0);
      cyc();
    end
    tg = 1'b0; lp = 1'b0; clr = 1'b0;

    // Clear dominates a simultaneous toggle while running.
    if (m1.mode != 1) begin
      tg = 1'b1; cyc(); tg = 1'b0;
    end
    repeat (137) cyc();
    lp = 1'b1; cyc(); lp = 1'b0;
    repeat (5) cyc();
    clr = 1'b1; tg = 1'b1; cyc(); clr = 1'b0; tg = 1'b0;
    check_all_zero("clear");
    repeat (20) cyc();

    // Asynchronous reset mid-run, between clock edges.
    tg = 1'b1; cyc(); tg = 1'b0;
    repeat (123) cyc();
    lp = 1'b1; cyc(); lp = 1'b0;
    repeat (3) cyc();
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    m1 = '{default: 0};
    m2 = '{default: 0};
    @(negedge clk);
    reset = 1'b0;
    repeat (5) cyc();

    // Full-day rollover on the fast instance.
    w_tg = 1'b1; cyc(); w_tg = 1'b0;
    for (int i = 0; i < 40000 && !m2.wrap && n_fail < 40; i++) cyc();
    chk("wrap_pulse", w_wrap, 1);
    chk("wrap_tick", w_tick, 1);
    chk("wrap_counts", {w_frac, w_sec, w_min, w_hour}, 0);
    cyc();
    chk("wrap_one_cycle", w_wrap, 0);
    chk("wrap_still_running", w_running, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
